// File: rtl/eq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// eq_ctrl_pkg
// Shared definitions for the serial equality controller:
//   - state_t   : controller FSM encoding (IDLE / COMPARE / DONE)
//   - SLICE_W   : bits examined per clock by the eq2 comparator slice
//   - idx_width : width of the slice index / mismatch_idx for a given WIDTH
// No ports (package).
// -----------------------------------------------------------------------------
package eq_ctrl_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPARE = 2'b01,
    DONE    = 2'b10
  } state_t;

  // max(1, clog2(WIDTH/SLICE_W)); a single-slice operand still needs a 1-bit index.
  function automatic int idx_width(input int width);
    int nslice;
    nslice = width / SLICE_W;
    if (nslice <= 1) return 1;
    return $clog2(nslice);
  endfunction

endpackage

// File: rtl/eq2.sv
// -----------------------------------------------------------------------------
// eq2
// 2-bit equality comparator slice, the shared compare resource.
// Ports:
//   a   [1:0] in  : operand A slice
//   b   [1:0] in  : operand B slice
//   out       out : 1 when a == b
// -----------------------------------------------------------------------------
module eq2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       out
);

  assign out = (a == b);

endmodule

// File: rtl/eq_serial_ctrl.sv
// -----------------------------------------------------------------------------
// eq_serial_ctrl
// Compares two WIDTH-bit operands for equality by stepping a single eq2 slice
// across them, one 2-bit slice per clock, lowest slice first.
//
// Parameters:
//   WIDTH      : operand width, even and >= 2 (NSLICE = WIDTH/2)
//   EARLY_EXIT : 1 = stop at the first mismatching slice, 0 = always scan all
//
// Ports:
//   clk          in  : rising-edge clock
//   reset        in  : asynchronous, active-high reset
//   start        in  : compare request, only looked at in IDLE
//   a, b         in  : operands, captured into shadow registers on accepted start
//   busy         out : high while in COMPARE or DONE
//   done         out : one-cycle pulse, result valid (registered)
//   out          out : 1 = operands equal; held until the next DONE (registered)
//   mismatch_idx out : lowest mismatching slice, 0 when equal (registered)
//
// Handshake: a start seen while state is IDLE is accepted on that clock edge;
// busy rises on the same edge and stays high through the DONE cycle. Starts
// while busy are dropped, not queued. done pulses high for exactly the DONE
// cycle, and out/mismatch_idx change only on the edge that raises done.
// -----------------------------------------------------------------------------
module eq_serial_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  bit EARLY_EXIT = 1'b1,
  localparam int NSLICE     = WIDTH / SLICE_W,
  localparam int IDX_W      = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             out,
  output logic [IDX_W-1:0] mismatch_idx
);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("eq_serial_ctrl: WIDTH must be even and >= 2");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               acc_q, acc_d;      // running "all slices equal so far"
  logic [IDX_W-1:0]   first_q, first_d;  // first mismatching slice seen
  logic [WIDTH-1:0]   sha_q, sha_d;
  logic [WIDTH-1:0]   shb_q, shb_d;
  logic               done_d;
  logic               out_d;
  logic [IDX_W-1:0]   midx_d;

  // ---------------------------------------------------------------------------
  // Slice select and the shared comparator
  // ---------------------------------------------------------------------------
  logic [SLICE_W-1:0] slice_a, slice_b;
  logic               slice_eq;

  // Constant part-selects under an index decode, so no variable shift is built.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_a = sha_q[i*SLICE_W +: SLICE_W];
        slice_b = shb_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  eq2 u_eq2 (
    .a   (slice_a),
    .b   (slice_b),
    .out (slice_eq)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    first_d = first_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    done_d  = 1'b0;
    out_d   = out;
    midx_d  = mismatch_idx;

    case (state_q)
      IDLE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          idx_d   = '0;
          acc_d   = 1'b1;
          first_d = '0;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        // Only the first mismatch is recorded; acc drops with it.
        if (!slice_eq && acc_q) begin
          acc_d   = 1'b0;
          first_d = idx_q;
        end

        if (!slice_eq && EARLY_EXIT) begin
          state_d = DONE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end

        // Outputs are loaded on the edge entering DONE so they are valid
        // during the done pulse; they come from the updated accumulator so a
        // mismatch in the final (or early-exit) slice is included.
        if (state_d == DONE) begin
          done_d = 1'b1;
          out_d  = acc_d;
          midx_d = acc_d ? '0 : first_d;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= 1'b0;
      first_q      <= '0;
      sha_q        <= '0;
      shb_q        <= '0;
      done         <= 1'b0;
      out          <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      first_q      <= first_d;
      sha_q        <= sha_d;
      shb_q        <= shb_d;
      done         <= done_d;
      out          <= out_d;
      mismatch_idx <= midx_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eq_serial_ctrl
// Three controllers share one stimulus stream: WIDTH=8 with early exit,
// WIDTH=8 full scan, and WIDTH=2 (operands are the low two bits).
// Expected entries are {out, mismatch_idx[1:0], busy_cycles[3:0], done_cycle[15:0]}.
// -----------------------------------------------------------------------------
module tb_eq_serial_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic       start;
  logic [7:0] a, b;

  logic       busy_ee, done_ee, out_ee;
  logic [1:0] midx_ee;
  logic       busy_fs, done_fs, out_fs;
  logic [1:0] midx_fs;
  logic       busy_w2, done_w2, out_w2;
  logic [0:0] midx_w2;

  eq_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .reset(rst), .start(start), .a(a), .b(b),
    .busy(busy_ee), .done(done_ee), .out(out_ee), .mismatch_idx(midx_ee)
  );

  eq_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_fs (
    .clk(clk), .reset(rst), .start(start), .a(a), .b(b),
    .busy(busy_fs), .done(done_fs), .out(out_fs), .mismatch_idx(midx_fs)
  );

  eq_serial_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b1)) dut_w2 (
    .clk(clk), .reset(rst), .start(start), .a(a[1:0]), .b(b[1:0]),
    .busy(busy_w2), .done(done_w2), .out(out_w2), .mismatch_idx(midx_w2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [22:0] exp_ee[$];
  logic [22:0] exp_fs[$];
  logic [22:0] exp_w2[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // s = edge number that samples start; done shows after edge s+lat-1.
  task automatic push(input int which, input logic o, input logic [1:0] mi,
                      input int s, input int lat);
    logic [22:0] e;
    e = {o, mi, 4'(lat), 16'(s + lat - 1)};
    case (which)
      0:       exp_ee.push_back(e);
      1:       exp_fs.push_back(e);
      default: exp_w2.push_back(e);
    endcase
  endtask

  task automatic pop_check(input int which, input logic o, input logic [1:0] mi, input int bc);
    logic [22:0] e;
    logic [22:0] got;
    string       nm;
    int          sz;
    got = {o, mi, 4'(bc), cyc[15:0]};
    case (which)
      0:       begin nm = "ee"; sz = exp_ee.size(); end
      1:       begin nm = "fs"; sz = exp_fs.size(); end
      default: begin nm = "w2"; sz = exp_w2.size(); end
    endcase
    if (sz == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected_done: got done=1 expected no done (cycle %0d)", nm, cyc);
    end else begin
      case (which)
        0:       e = exp_ee.pop_front();
        1:       e = exp_fs.pop_front();
        default: e = exp_w2.pop_front();
      endcase
      check({nm, "_result{out,idx}"}, 32'(got[22:20]), 32'(e[22:20]));
      check({nm, "_timing{busy,cycle}"}, 32'(got[19:0]), 32'(e[19:0]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: busy run length and result at every done pulse
  // ---------------------------------------------------------------------------
  int bc_ee = 0, bc_fs = 0, bc_w2 = 0;

  always @(negedge clk) begin
    bc_ee = busy_ee ? bc_ee + 1 : 0;
    bc_fs = busy_fs ? bc_fs + 1 : 0;
    bc_w2 = busy_w2 ? bc_w2 + 1 : 0;
    if (done_ee) pop_check(0, out_ee, midx_ee, bc_ee);
    if (done_fs) pop_check(1, out_fs, midx_fs, bc_fs);
    if (done_w2) pop_check(2, out_w2, {1'b0, midx_w2}, bc_w2);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic run_vec(input logic [7:0] va, input logic [7:0] vb,
                         input logic o8, input logic [1:0] mi8,
                         input int lat_ee, input int lat_fs, input logic o2);
    int c;
    @(negedge clk);
    a = va; b = vb; start = 1'b1; c = cyc;
    push(0, o8, mi8, c + 1, lat_ee);
    push(1, o8, mi8, c + 1, lat_fs);
    push(2, o2, 2'd0, c + 1, 2);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  // Start held high for edges c+1..c+h: each compare restarts one idle cycle
  // after DONE, so the next accepting edge is lat+1 after the previous one.
  task automatic push_seq(input int which, input logic o, input logic [1:0] mi,
                          input int c, input int h, input int lat);
    int s;
    s = c + 1;
    while (s <= c + h) begin
      push(which, o, mi, s, lat);
      s = s + lat + 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int c0;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy",  32'(busy_ee), 32'd0);
    check("reset_done",  32'(done_ee), 32'd0);
    check("reset_out",   32'(out_ee),  32'd0);
    check("reset_idx",   32'(midx_ee), 32'd0);
    check("reset_w2_out", 32'(out_w2), 32'd0);

    //        a      b      out idx ee fs  w2out
    run_vec(8'hA5, 8'hA5, 1'b1, 2'd0, 5, 5, 1'b1);  // equal
    run_vec(8'h02, 8'h03, 1'b0, 2'd0, 2, 5, 1'b0);  // slice 0 mismatch
    run_vec(8'hC0, 8'h40, 1'b0, 2'd3, 5, 5, 1'b1);  // top slice mismatch
    check("hold_out_idle", 32'(out_ee),  32'd0);
    check("hold_idx_idle", 32'(midx_ee), 32'd3);
    run_vec(8'hFF, 8'h0E, 1'b0, 2'd0, 2, 5, 1'b0);  // several mismatches
    run_vec(8'h30, 8'h00, 1'b0, 2'd2, 4, 5, 1'b1);  // early exit at slice 2

    // Second start while busy, operand change after capture.
    @(negedge clk);
    a = 8'h11; b = 8'h11; start = 1'b1; c0 = cyc;
    push(0, 1'b1, 2'd0, c0 + 1, 5);
    push(1, 1'b1, 2'd0, c0 + 1, 5);
    push(2, 1'b1, 2'd0, c0 + 1, 2);
    @(negedge clk);
    start = 1'b0; a = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Start held high: back-to-back compares.
    @(negedge clk);
    a = 8'h3C; b = 8'h3D; start = 1'b1; c0 = cyc;
    push_seq(0, 1'b0, 2'd0, c0, 13, 2);
    push_seq(1, 1'b0, 2'd0, c0, 13, 5);
    push_seq(2, 1'b0, 2'd0, c0, 13, 2);
    repeat (13) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during COMPARE: leave mismatch_idx=3 behind, then abort a compare.
    run_vec(8'hC0, 8'h40, 1'b0, 2'd3, 5, 5, 1'b1);
    @(negedge clk);
    a = 8'hA5; b = 8'hA5; start = 1'b1; c0 = cyc;
    push(2, 1'b1, 2'd0, c0 + 1, 2);  // the 2-bit unit finishes before reset
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    check("busy_mid_compare", 32'(busy_ee), 32'd1);
    check("idx_held_busy",    32'(midx_ee), 32'd3);
    rst = 1'b1;
    #1;
    check("rst_ee_busy", 32'(busy_ee), 32'd0);
    check("rst_ee_done", 32'(done_ee), 32'd0);
    check("rst_ee_out",  32'(out_ee),  32'd0);
    check("rst_ee_idx",  32'(midx_ee), 32'd0);
    check("rst_fs_busy", 32'(busy_fs), 32'd0);
    check("rst_fs_idx",  32'(midx_fs), 32'd0);
    check("rst_w2_done", 32'(done_w2), 32'd0);
    check("rst_w2_out",  32'(out_w2),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_vec(8'hA5, 8'hA5, 1'b1, 2'd0, 5, 5, 1'b1);

    check("ee_queue_drained", 32'(exp_ee.size()), 32'd0);
    check("fs_queue_drained", 32'(exp_fs.size()), 32'd0);
    check("w2_queue_drained", 32'(exp_w2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
